// File: rtl/juego_pkg.sv
// Shared types and constants for the LED reaction game referee.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package juego_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_LIT,
    ST_POINT,
    ST_HOLD,
    ST_DONE
  } estado_t;

  localparam int         SCORE_W   = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1

  typedef logic [SCORE_W-1:0] score_t;

  // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/generador_aleatorio.sv
// 8-bit free-running LFSR used to randomise the pre-LED delay.
// Latency: new value every enabled cycle; seed load takes effect next cycle.
// Backpressure: none; en simply freezes the sequence.
module generador_aleatorio
  import juego_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] valor
);

  // Advance the sequence; an all-zero state would lock up, so it is re-seeded.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      valor <= LFSR_SEED;
    end else if (load) begin
      valor <= seed;
    end else if (en) begin
      if (valor == 8'd0) valor <= LFSR_SEED;
      else               valor <= lfsr_next(valor);
    end
  end

endmodule

// File: rtl/arbitro_ronda.sv
// Round referee: arms players, random delay, LED, judges first press/foul, keeps score.
// Latency: all outputs registered, valid in the cycle the state register holds the state.
// Backpressure: a button held while arming stalls the round until both are released.
module arbitro_ronda
  import juego_pkg::*;
#(
  parameter logic [15:0]        WAIT_MIN  = 16'd200,
  parameter logic [15:0]        T_REACT   = 16'd1000,
  parameter logic [15:0]        T_HOLD    = 16'd500,
  parameter logic [SCORE_W-1:0] WIN_SCORE = 4'd5
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               BotonA,
  input  logic               BotonB,
  output logic               LedEncendido,
  output logic               Apagar,
  output logic               ModifA,
  output logic               ModifB,
  output logic               GanadorA,
  output logic               GanadorB,
  output logic [SCORE_W-1:0] ScoreA,
  output logic [SCORE_W-1:0] ScoreB,
  output logic               Falta
);

  estado_t     estado, estado_d;
  logic [15:0] cnt, cnt_d;
  logic [7:0]  lfsr;
  score_t      score_a_d, score_b_d;
  logic        punto_a, punto_b;
  logic        led_d, apagar_d, modif_a_d, modif_b_d, falta_d, gan_a_d, gan_b_d;

  generador_aleatorio u_lfsr (
    .clock (clock),
    .rst   (Reset),
    .en    (1'b1),
    .load  (1'b0),
    .seed  (LFSR_SEED),
    .valor (lfsr)
  );

  // Next state, counter and scores; outputs are the registered view of the next state.
  always_comb begin
    estado_d  = estado;
    cnt_d     = cnt;
    score_a_d = ScoreA;
    score_b_d = ScoreB;
    punto_a   = 1'b0;
    punto_b   = 1'b0;
    falta_d   = 1'b0;
    modif_a_d = 1'b0;
    modif_b_d = 1'b0;
    case (estado)
      ST_IDLE: begin
        if (Start) begin
          estado_d  = ST_ARM;
          score_a_d = '0;
          score_b_d = '0;
        end
      end
      ST_ARM: begin
        if (!BotonA && !BotonB) begin
          estado_d = ST_WAIT;
          cnt_d    = WAIT_MIN + {8'd0, lfsr};
        end
      end
      ST_WAIT: begin
        if (BotonA || BotonB) begin
          // Early press: the fouling player hands the point to the opponent.
          falta_d = 1'b1;
          if (BotonA && BotonB) begin
            estado_d = ST_HOLD;
            cnt_d    = T_HOLD;
          end else begin
            estado_d = ST_POINT;
            punto_a  = BotonB;
            punto_b  = BotonA;
          end
        end else if (cnt == 16'd0) begin
          estado_d = ST_LIT;
          cnt_d    = T_REACT;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      ST_LIT: begin
        if (BotonA && BotonB) begin
          estado_d = ST_HOLD;
          cnt_d    = T_HOLD;
        end else if (BotonA || BotonB) begin
          estado_d = ST_POINT;
          punto_a  = BotonA;
          punto_b  = BotonB;
        end else if (cnt == 16'd0) begin
          estado_d = ST_HOLD;
          cnt_d    = T_HOLD;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      ST_POINT: begin
        if (ScoreA == WIN_SCORE || ScoreB == WIN_SCORE) begin
          estado_d = ST_DONE;
        end else begin
          estado_d = ST_HOLD;
          cnt_d    = T_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == 16'd0) estado_d = ST_ARM;
        else              cnt_d    = cnt - 16'd1;
      end
      ST_DONE: begin
        if (Start) begin
          estado_d  = ST_ARM;
          score_a_d = '0;
          score_b_d = '0;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
    // Score is bumped on the way into POINT so ModifX and ScoreX land together.
    if (punto_a && ScoreA < WIN_SCORE) begin
      score_a_d = ScoreA + score_t'(1);
      modif_a_d = 1'b1;
    end
    if (punto_b && ScoreB < WIN_SCORE) begin
      score_b_d = ScoreB + score_t'(1);
      modif_b_d = 1'b1;
    end
    led_d    = (estado_d == ST_LIT);
    apagar_d = (estado == ST_LIT) && (estado_d != ST_LIT);
    gan_a_d  = (estado_d == ST_DONE) && (score_a_d == WIN_SCORE);
    gan_b_d  = (estado_d == ST_DONE) && (score_b_d == WIN_SCORE);
  end

  // State, counter, scores and output registers; reset aborts any round in progress.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      estado       <= ST_IDLE;
      cnt          <= 16'd0;
      ScoreA       <= '0;
      ScoreB       <= '0;
      LedEncendido <= 1'b0;
      Apagar       <= 1'b0;
      ModifA       <= 1'b0;
      ModifB       <= 1'b0;
      GanadorA     <= 1'b0;
      GanadorB     <= 1'b0;
      Falta        <= 1'b0;
    end else begin
      estado       <= estado_d;
      cnt          <= cnt_d;
      ScoreA       <= score_a_d;
      ScoreB       <= score_b_d;
      LedEncendido <= led_d;
      Apagar       <= apagar_d;
      ModifA       <= modif_a_d;
      ModifB       <= modif_b_d;
      GanadorA     <= gan_a_d;
      GanadorB     <= gan_b_d;
      Falta        <= falta_d;
    end
  end

endmodule

// File: tb/tb_arbitro_ronda.sv
module tb_arbitro_ronda;

  localparam logic [15:0] WMIN = 16'd4;
  localparam logic [15:0] TRE  = 16'd10;
  localparam logic [15:0] THO  = 16'd3;
  localparam logic [3:0]  WIN  = 4'd5;

  logic       clock  = 1'b0;
  logic       Reset  = 1'b1;
  logic       Start  = 1'b0;
  logic       BotonA = 1'b0;
  logic       BotonB = 1'b0;
  logic       LedEncendido, Apagar, ModifA, ModifB, GanadorA, GanadorB, Falta;
  logic [3:0] ScoreA, ScoreB;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_lfsr;

  arbitro_ronda #(
    .WAIT_MIN  (WMIN),
    .T_REACT   (TRE),
    .T_HOLD    (THO),
    .WIN_SCORE (WIN)
  ) dut (
    .clock        (clock),
    .Reset        (Reset),
    .Start        (Start),
    .BotonA       (BotonA),
    .BotonB       (BotonB),
    .LedEncendido (LedEncendido),
    .Apagar       (Apagar),
    .ModifA       (ModifA),
    .ModifB       (ModifB),
    .GanadorA     (GanadorA),
    .GanadorB     (GanadorB),
    .ScoreA       (ScoreA),
    .ScoreB       (ScoreB),
    .Falta        (Falta)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5, stepping every cycle out of reset.
  always @(posedge clock or posedge Reset) begin
    if (Reset) ref_lfsr <= 8'hA5;
    else       ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // {LedEncendido, Apagar, ModifA, ModifB, Falta}
  function automatic int flags();
    return int'({LedEncendido, Apagar, ModifA, ModifB, Falta});
  endfunction

  // Called at the negedge just before the edge on which ARM sees both buttons low.
  task automatic wait_led_from_arm(input string tag);
    int n_exp;
    int n;
    n_exp = int'(WMIN) + int'(ref_lfsr) + 1;
    @(negedge clock);
    n = 0;
    while (!LedEncendido && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check(tag, n, n_exp);
  endtask

  initial begin
    int c;
    ticks(2);
    check("reset_outputs",
          int'({LedEncendido, Apagar, ModifA, ModifB, GanadorA, GanadorB, Falta, ScoreA, ScoreB}), 0);
    Reset = 1'b0;

    // Round 1: A presses 3 cycles after the LED comes on.
    Start = 1'b1;
    ticks(1);
    Start = 1'b0;
    wait_led_from_arm("r1_led_latency");
    ticks(2);
    BotonA = 1'b1;
    ticks(1);
    check("r1_press_flags", flags(), 5'b01100);
    check("r1_scoreA", int'(ScoreA), 1);
    check("r1_scoreB", int'(ScoreB), 0);
    BotonA = 1'b0;
    ticks(1);
    check("r1_point_flags", flags(), 0);
    ticks(int'(THO) + 1);

    // Round 2: exact re-arm timing, then a tie in LIT.
    wait_led_from_arm("r2_rearm_latency");
    BotonA = 1'b1;
    BotonB = 1'b1;
    ticks(1);
    check("r2_tie_flags", flags(), 5'b01000);
    check("r2_tie_scoreA", int'(ScoreA), 1);
    check("r2_tie_scoreB", int'(ScoreB), 0);

    // Buttons held through HOLD into ARM: the FSM must stall there.
    ticks(300);
    check("r2_stall_led", int'(LedEncendido), 0);
    check("r2_stall_falta", int'(Falta), 0);
    BotonA = 1'b0;
    BotonB = 1'b0;

    // Round 3: release from stall, then timeout with Start held (must be ignored).
    wait_led_from_arm("r3_stall_release_latency");
    Start = 1'b1;
    c = 0;
    while (LedEncendido && c < 100) begin
      c++;
      ticks(1);
    end
    Start = 1'b0;
    check("r3_led_high_cycles", c, int'(TRE) + 1);
    check("r3_timeout_flags", flags(), 5'b01000);
    check("r3_timeout_scoreA", int'(ScoreA), 1);
    check("r3_timeout_scoreB", int'(ScoreB), 0);
    ticks(int'(THO) + 1);

    // Round 4: B presses during WAIT -> foul, point to A, no LED.
    ticks(2);
    BotonB = 1'b1;
    ticks(1);
    check("r4_foul_flags", flags(), 5'b00101);
    check("r4_foul_scoreA", int'(ScoreA), 2);
    check("r4_foul_scoreB", int'(ScoreB), 0);
    BotonB = 1'b0;
    ticks(1);
    check("r4_after_flags", flags(), 0);
    ticks(int'(THO) + 1);

    // Rounds 5..7: A takes the remaining points and the match.
    for (int k = 3; k <= 5; k++) begin
      wait_led_from_arm($sformatf("r%0d_led_latency", k + 2));
      BotonA = 1'b1;
      ticks(1);
      check($sformatf("r%0d_flags", k + 2), flags(), 5'b01100);
      check($sformatf("r%0d_scoreA", k + 2), int'(ScoreA), k);
      BotonA = 1'b0;
      ticks(1);
      if (k < 5) begin
        check($sformatf("r%0d_ganadorA", k + 2), int'(GanadorA), 0);
        ticks(int'(THO) + 1);
      end else begin
        check("done_ganadores", int'({GanadorA, GanadorB}), 2'b10);
      end
    end
    ticks(5);
    check("done_hold_ganadorA", int'(GanadorA), 1);
    check("done_hold_scoreA", int'(ScoreA), 5);
    check("done_hold_led", int'(LedEncendido), 0);

    // Start from DONE: clears scores and winner, goes straight to ARM.
    Start = 1'b1;
    ticks(1);
    Start = 1'b0;
    check("restart_ganadores", int'({GanadorA, GanadorB}), 0);
    check("restart_scores", int'({ScoreA, ScoreB}), 0);
    wait_led_from_arm("r8_led_latency");
    BotonB = 1'b1;
    ticks(1);
    check("r8_flags", flags(), 5'b01010);
    check("r8_scoreB", int'(ScoreB), 1);
    BotonB = 1'b0;
    ticks(1);
    ticks(int'(THO) + 1);

    // Reset in the middle of LIT aborts the round and clears everything.
    wait_led_from_arm("r9_led_latency");
    Reset = 1'b1;
    ticks(1);
    check("midlit_reset_outputs",
          int'({LedEncendido, Apagar, ModifA, ModifB, GanadorA, GanadorB, Falta, ScoreA, ScoreB}), 0);
    Reset = 1'b0;
    ticks(300);
    check("idle_no_led", int'(LedEncendido), 0);
    Start = 1'b1;
    ticks(1);
    Start = 1'b0;
    wait_led_from_arm("post_reset_led_latency");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
